// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: load responses beat buffered ALU results, which beat bypass.
// Optional combinational forwarding lookup is built when RF_WB_FWD_EN is defined.
module rf_writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RAW   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [RAW-1:0]           alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_issue,
  input  logic [RAW-1:0]           ld_issue_rd,
  input  logic                     ld_valid,
  input  logic [RAW-1:0]           ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     rf_we,
  output logic [RAW-1:0]           rf_addr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [31:0]              ld_busy,
  output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef RF_WB_FWD_EN
  ,
  input  logic [RAW-1:0]           q_addr,
  output logic                     q_hit,
  output logic [XLEN-1:0]          q_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ALU handshake: a transfer happens on alu_valid && alu_ready; alu_ready
  // depends only on rst and registered occupancy, never on alu_valid.
  logic [RAW-1:0]  rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic alu_xfer, alu_live, ld_win, fifo_win, byp_win, push, pop;
  logic [31:0] busy_next;

  assign alu_ready = !rst && (fifo_cnt != CW'(DEPTH));
  assign alu_xfer  = alu_valid && alu_ready;
  assign alu_live  = alu_xfer && (alu_rd != '0);
  assign ld_win    = ld_valid && (ld_rd != '0);
  assign fifo_win  = !ld_win && (fifo_cnt != '0);
  assign byp_win   = !ld_win && (fifo_cnt == '0) && alu_live;
  assign push      = alu_live && !byp_win;
  assign pop       = fifo_win;

  // Set beats clear so an issue racing a response to the same rd stays busy.
  always_comb begin
    busy_next = ld_busy;
    if (ld_valid) busy_next[ld_rd] = 1'b0;
    if (ld_issue) busy_next[ld_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      ld_busy  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      rf_we   <= ld_win || fifo_win || byp_win;
      ld_busy <= busy_next;
      if (ld_win) begin
        rf_addr  <= ld_rd;
        rf_wdata <= ld_data;
      end else if (fifo_win) begin
        rf_addr  <= rd_mem[rd_ptr];
        rf_wdata <= data_mem[rd_ptr];
      end else if (byp_win) begin
        rf_addr  <= alu_rd;
        rf_wdata <= alu_data;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= alu_rd;
      data_mem[wr_ptr] <= alu_data;
    end
  end

`ifdef RF_WB_FWD_EN
  logic [PW-1:0] q_idx;

  // Scan oldest to youngest so the last match is the youngest; rf_* overrides.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    q_idx  = '0;
    if (q_addr != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_idx = rd_ptr + PW'(i);
        if ((CW'(i) < fifo_cnt) && (rd_mem[q_idx] == q_addr)) begin
          q_hit  = 1'b1;
          q_data = data_mem[q_idx];
        end
      end
      if (rf_we && (rf_addr == q_addr)) begin
        q_hit  = 1'b1;
        q_data = rf_wdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_writeback_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int RAW   = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic            alu_ready;
  logic [RAW-1:0]  alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue;
  logic [RAW-1:0]  ld_issue_rd;
  logic            ld_valid;
  logic [RAW-1:0]  ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            rf_we;
  logic [RAW-1:0]  rf_addr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     ld_busy;
  logic [CW-1:0]   fifo_cnt;
`ifdef RF_WB_FWD_EN
  logic [RAW-1:0]  q_addr;
  logic            q_hit;
  logic [XLEN-1:0] q_data;
`endif

  rf_writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .RAW(RAW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .ld_busy(ld_busy), .fifo_cnt(fifo_cnt)
`ifdef RF_WB_FWD_EN
    , .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  logic [RAW+XLEN-1:0] exp_q[$];   // {rd, data}, oldest at front
  logic [31:0]         exp_busy;
  logic                exp_we;
  logic [RAW-1:0]      exp_addr;
  logic [XLEN-1:0]     exp_data;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !rst && (exp_q.size() < DEPTH);
  endfunction

  task automatic model_step();
    bit acc, bypassed;
    if (rst) begin
      exp_q.delete();
      exp_busy = '0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      return;
    end
    acc      = alu_valid && (exp_q.size() < DEPTH) && (alu_rd != 0);
    bypassed = 1'b0;
    exp_we   = 1'b1;
    if (ld_valid && ld_rd != 0) begin
      exp_addr = ld_rd;
      exp_data = ld_data;
    end else if (exp_q.size() > 0) begin
      {exp_addr, exp_data} = exp_q.pop_front();
    end else if (acc) begin
      exp_addr = alu_rd;
      exp_data = alu_data;
      bypassed = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    if (acc && !bypassed) exp_q.push_back({alu_rd, alu_data});
    if (ld_valid) exp_busy[ld_rd] = 1'b0;
    if (ld_issue) exp_busy[ld_issue_rd] = 1'b1;
    exp_busy[0] = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registers.
  task automatic tick();
    @(negedge clk);
    check("alu_ready", alu_ready, model_ready());
`ifdef RF_WB_FWD_EN
    begin
      logic            hit = 1'b0;
      logic [XLEN-1:0] dat = '0;
      if (q_addr != 0) begin
        foreach (exp_q[i])
          if (exp_q[i][RAW+XLEN-1:XLEN] == q_addr) begin
            hit = 1'b1;
            dat = exp_q[i][XLEN-1:0];
          end
        if (exp_we && exp_addr == q_addr) begin
          hit = 1'b1;
          dat = exp_data;
        end
      end
      check("q_hit", q_hit, hit);
      check("q_data", q_data, dat);
    end
`endif
    @(posedge clk);
    model_step();
    #1;
    check("rf_we", rf_we, exp_we);
    check("rf_addr", rf_addr, exp_addr);
    check("rf_wdata", rf_wdata, exp_data);
    check("ld_busy", ld_busy, exp_busy);
    check("fifo_cnt", fifo_cnt, exp_q.size());
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
`ifdef RF_WB_FWD_EN
    q_addr = '0;
`endif
  endtask

  task automatic drive_alu(input logic v, input logic [RAW-1:0] rd, input logic [XLEN-1:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic drive_ld(input logic v, input logic [RAW-1:0] rd, input logic [XLEN-1:0] d);
    ld_valid = v; ld_rd = rd; ld_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int n_wr;
    logic [RAW-1:0] order[8];
    logic [31:0] busy_snap;

    exp_busy = '0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_we", rf_we, 0);
    check("rst_cnt", fifo_cnt, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", alu_ready, 1);

    // ALU bypass
    drive_alu(1, 5, 32'h1234);
    tick();
    check("byp_addr", rf_addr, 5);
    check("byp_data", rf_wdata, 32'h1234);
    check("byp_cnt", fifo_cnt, 0);
    idle();
    tick();

    // Load vs ALU contention
    drive_ld(1, 7, 32'hAAAA0000);
    drive_alu(1, 3, 32'h55);
    tick();
    check("cont_ld_addr", rf_addr, 7);
    check("cont_cnt1", fifo_cnt, 1);
    idle();
    tick();
    check("cont_alu_addr", rf_addr, 3);
    check("cont_alu_data", rf_wdata, 32'h55);
    check("cont_cnt0", fifo_cnt, 0);

    // FIFO full under a held load response
    k = 1;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      drive_ld(1, 9, $urandom);
      drive_alu(k <= 6, k[RAW-1:0], 32'h100 + k);
      acc = model_ready();
      tick();
      if (acc && k <= 6) k++;
    end
    check("full_accepts", k - 1, 4);
    check("full_cnt", fifo_cnt, 4);
    #1;
    check("full_ready", alu_ready, 0);
    drive_ld(0, 0, 0);
    n_wr = 0;
    for (int c = 0; c < 20 && n_wr < 6; c++) begin
      bit acc;
      drive_alu(k <= 6, k[RAW-1:0], 32'h100 + k);
      acc = model_ready();
      tick();
      if (acc && k <= 6) k++;
      if (rf_we) begin
        order[n_wr] = rf_addr;
        n_wr++;
      end
    end
    check("full_nwrites", n_wr, 6);
    for (int i = 0; i < 6; i++) check("full_order", order[i], i + 1);
    idle();
    tick();

    // Scoreboard and x0
    ld_issue = 1; ld_issue_rd = 12;
    tick();
    check("sb_set", ld_busy[12], 1);
    drive_ld(1, 12, 32'hCAFE);
    tick();
    check("sb_set_wins", ld_busy[12], 1);
    idle();
    drive_ld(1, 12, 32'hBEEF);
    tick();
    check("sb_clear", ld_busy[12], 0);
    idle();
    drive_alu(1, 0, 32'hDEAD);
    tick();
    check("x0_alu_no_we", rf_we, 0);
    idle();
    busy_snap = ld_busy;
    ld_issue = 1; ld_issue_rd = 0;
    tick();
    check("x0_issue", ld_busy, busy_snap);
    idle();

    // Reset mid-operation
    ld_issue = 1; ld_issue_rd = 4;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      drive_ld(1, 9, $urandom);
      drive_alu(1, RAW'(20 + c), $urandom);
      tick();
    end
    check("mid_cnt3", fifo_cnt, 3);
    check("mid_busy4", ld_busy[4], 1);
    idle();
    rst = 1'b1;
    tick();
    check("mid_cnt0", fifo_cnt, 0);
    check("mid_busy0", ld_busy, 0);
    check("mid_we0", rf_we, 0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("mid_no_write", rf_we, 0);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      alu_valid   = ($urandom_range(0, 2) != 0);
      alu_rd      = RAW'($urandom_range(0, 9));
      alu_data    = $urandom;
      ld_issue    = ($urandom_range(0, 2) == 0);
      ld_issue_rd = RAW'($urandom_range(0, 15));
      ld_valid    = ($urandom_range(0, 3) == 0);
      ld_rd       = RAW'($urandom_range(0, 15));
      ld_data     = $urandom;
`ifdef RF_WB_FWD_EN
      q_addr      = RAW'($urandom_range(0, 9));
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
